// File: rtl/sha256_round_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// sha256_round_ctrl
// Sequencer for one SHA-256 compression of a 512-bit block. It steers the
// eight working registers (a..h), supplies the round index for the K ROM and
// message schedule, and strobes the digest registers (H0..H7). Blocks are
// taken from the padding/input stage through a valid/ready handshake.
//
// Ports
//   CLK           clock, all state changes on the rising edge
//   RST           asynchronous, active-high reset
//   blk_valid     input block (and first_blk) is valid
//   first_blk     block starts a new message: load the IV into H0..H7
//   abort         synchronous cancel of the block in progress
//   blk_ready     controller can accept a block
//   reg_start     load enable for all eight working registers
//   reg_sel_init  working-register mux: 1 = H0..H7, 0 = round output
//   round_idx     current round t (selects K[t] and W[t])
//   w_load        W[t] comes from the block words (t < 16)
//   h_init        load the IV constants into H0..H7
//   h_update      H[i] <= H[i] + working[i]
//   busy          a block is in progress
//   done          one-cycle pulse, digest registers hold the updated value
// ---------------------------------------------------------------------------
module sha256_round_ctrl #(
  parameter int NUM_ROUNDS = 64,
  parameter int CNT_W      = 6
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             blk_valid,
  input  logic             first_blk,
  input  logic             abort,
  output logic             blk_ready,
  output logic             reg_start,
  output logic             reg_sel_init,
  output logic [CNT_W-1:0] round_idx,
  output logic             w_load,
  output logic             h_init,
  output logic             h_update,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    ROUND = 3'd2,
    FINAL = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] round_cnt;
  logic [CNT_W-1:0] next_cnt;
  logic             last_round;
  logic             handshake;

  assign last_round = (round_cnt == CNT_W'(NUM_ROUNDS - 1));

  // Ready is held low while RST is asserted so nothing can be accepted
  // during reset; abort always wins over an offered block.
  assign blk_ready = (state == IDLE) && !abort && !RST;
  assign handshake = blk_valid && blk_ready;
  assign h_init    = handshake && first_blk;

  // State register and round counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      round_cnt <= '0;
    end else begin
      state     <= next_state;
      round_cnt <= next_cnt;
    end
  end

  // Next-state logic. The counter only advances in ROUND and is cleared on
  // the last round so it never wraps; any abort outside IDLE returns home.
  always_comb begin
    next_state = state;
    next_cnt   = '0;
    case (state)
      IDLE: begin
        if (handshake) next_state = INIT;
      end
      INIT: begin
        next_state = ROUND;
      end
      ROUND: begin
        if (last_round) begin
          next_state = FINAL;
          next_cnt   = '0;
        end else begin
          next_cnt = round_cnt + 1'b1;
        end
      end
      FINAL: begin
        next_state = DONE;
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
    if (abort && (state != IDLE)) begin
      next_state = IDLE;
      next_cnt   = '0;
    end
  end

  // Output decode. Register loads, the digest update and done are masked by
  // abort in the same cycle so an aborted block never touches H0..H7.
  always_comb begin
    reg_start    = 1'b0;
    reg_sel_init = 1'b0;
    w_load       = 1'b0;
    h_update     = 1'b0;
    done         = 1'b0;
    busy         = (state != IDLE);
    round_idx    = round_cnt;
    case (state)
      INIT: begin
        reg_start    = !abort;
        reg_sel_init = 1'b1;
      end
      ROUND: begin
        reg_start = !abort;
        w_load    = (32'(round_cnt) < 32'd16);
      end
      FINAL: begin
        h_update = !abort;
      end
      DONE: begin
        done = !abort;
      end
      default: begin
        reg_start = 1'b0;
      end
    endcase
  end

endmodule
